clk_ratio_monitor: RTL and testbench

CLK_RATIO_MONITOR -- requirements
Module: clk_ratio_monitor

---
 rtl/clk_mon_pkg.sv | 17 +
 rtl/sync_2ff.sv | 26 ++
 rtl/clk_ratio_monitor.sv | 181 ++++++++++++++++++
 tb/tb_clk_ratio_monitor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock-ratio monitor.
// Holds the monitor state encoding and the error-counter width and
// saturation value used by clk_ratio_monitor.
package clk_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HUNT    = 3'd1,
    ST_LOCKING = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_ERROR   = 3'd4
  } mon_state_t;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Ports:
//   clk     - destination clock
//   reset_L - asynchronous active-low reset, both flops clear to 0
//   d       - asynchronous input
//   q       - synchronized output, two clk edges after d settles
module sync_2ff (
  input  logic clk,
  input  logic reset_L,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_ratio_monitor.sv
// Clock-ratio monitor: measures the period of clk_in in clk cycles and
// locks when LOCK_CNT consecutive periods equal DIV exactly. A wrong
// period or a stopped clk_in (no rise within 2*DIV cycles) moves the
// monitor to a sticky error state until clr_err or reset.
// Optional build macro CLK_RATIO_MONITOR_DUTY_EN: also measure the high
// time and treat a high time other than DIV/2 as a bad period.
// Ports:
//   clk     - system clock, all state on its rising edge
//   reset_L - asynchronous active-low reset
//   clk_in  - monitored clock, asynchronous to clk
//   clr_err - synchronous restart to HUNT, clears err, keeps err_cnt
//   locked  - high while the measured period matches DIV
//   err     - sticky error flag
//   period  - last measured period in clk cycles
//   err_cnt - count of bad periods and timeouts, saturating at 255
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter  int DIV      = 8,
  parameter  int LOCK_CNT = 4,
  localparam int CW       = $clog2(2*DIV+1)
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 clk_in,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err,
  output logic [CW-1:0]        period,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int            GW        = $clog2(LOCK_CNT+1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(2*DIV);
  localparam logic [CW-1:0] PER_GOOD  = CW'(DIV);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT-1);

  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic       sync_p0;
  logic       sync_p1;
  logic       rise_p2;
  logic [CW-1:0] cnt;
  logic       timeout;
  logic       good_rise;
  logic       bad_rise;
  logic       bad_duty;
  logic       bad_meas;
  logic       stalled;
  logic       err_inc;
  logic [GW-1:0] good_cnt;
  logic [GW-1:0] good_nxt;
  mon_state_t state;
  mon_state_t state_nxt;

  // ---- stage p0: clk_in brought into the clk domain
  sync_2ff u_sync (
    .clk     (clk),
    .reset_L (reset_L),
    .d       (clk_in),
    .q       (sync_p0)
  );

  // ---- stage p1/p2: registered edge detection, rise is 1 clk wide
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sync_p1 <= 1'b0;
      rise_p2 <= 1'b0;
    end else begin
      sync_p1 <= sync_p0;
      rise_p2 <= sync_p0 & ~sync_p1;
    end
  end

  // ---- measurement: cycles since the last rise or timeout restart
  // A timeout restarts the counter so a long stall produces repeated
  // timeout events; the stalled flag keeps ERROR from counting them twice.
  assign timeout   = !rise_p2 && (cnt == CNT_MAX);
  assign good_rise = rise_p2 && (cnt == PER_GOOD);
  assign bad_rise  = rise_p2 && (cnt != PER_GOOD);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt     <= '0;
      period  <= '0;
      stalled <= 1'b0;
    end else begin
      if (rise_p2 || timeout) cnt <= CW'(1);
      else                    cnt <= cnt_sat_inc(cnt);
      if (rise_p2) period <= cnt;
      if (rise_p2)      stalled <= 1'b0;
      else if (timeout) stalled <= 1'b1;
    end
  end

`ifdef CLK_RATIO_MONITOR_DUTY_EN
  localparam logic [CW-1:0] HIGH_GOOD = CW'(DIV/2);

  logic          fall_p2;
  logic [CW-1:0] hi_cnt;

  // High time is the count since the last rise, sampled at the fall.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fall_p2 <= 1'b0;
      hi_cnt  <= '0;
    end else begin
      fall_p2 <= ~sync_p0 & sync_p1;
      if (rise_p2) hi_cnt <= CW'(1);
      else         hi_cnt <= cnt_sat_inc(hi_cnt);
    end
  end

  assign bad_duty = fall_p2 && (hi_cnt != HIGH_GOOD);
`else
  assign bad_duty = 1'b0;
`endif

  assign bad_meas = bad_rise || bad_duty || timeout;

  // ---- control FSM
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= ST_IDLE;
      good_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      if (err_inc) err_cnt <= err_sat_inc(err_cnt);
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_inc   = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_HUNT;
      ST_HUNT: begin
        // The first rise only opens a measurement window.
        if (rise_p2) begin
          state_nxt = ST_LOCKING;
          good_nxt  = '0;
        end
      end
      ST_LOCKING: begin
        if (bad_meas) begin
          state_nxt = ST_ERROR;
          err_inc   = 1'b1;
        end else if (good_rise) begin
          if (good_cnt == GOOD_LAST) state_nxt = ST_LOCKED;
          else                       good_nxt  = good_cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (bad_meas) begin
          state_nxt = ST_ERROR;
          err_inc   = 1'b1;
        end
      end
      ST_ERROR: begin
        if (timeout && !stalled) err_inc = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Restart overrides any transition, but an error seen this cycle
    // is still counted.
    if (clr_err && (state != ST_IDLE)) state_nxt = ST_HUNT;
  end

  assign locked = (state == ST_LOCKED);
  assign err    = (state == ST_ERROR);

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Self-checking bench for clk_ratio_monitor (DIV=8, LOCK_CNT=4).
// Define CLK_RATIO_MONITOR_DUTY_EN for both bench and RTL to exercise the
// duty-cycle check.
module tb_clk_ratio_monitor;

  localparam int D  = 8;
  localparam int LK = 4;
  localparam int M_IDLE = 0, M_HUNT = 1, M_LOCKING = 2, M_LOCKED = 3, M_ERROR = 4;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       clk_in = 1'b0;
  logic       clr_err = 1'b0;
  logic       locked;
  logic       err;
  logic [4:0] period;
  logic [7:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: timestamps of edges rather than counters
  int       m_state;
  int       m_good;
  int       m_period;
  int       m_errcnt;
  int       m_stalled;
  int       m_edge;
  int       m_ref;
  int       m_href;
  logic [4:0] m_lvl;

  clk_ratio_monitor #(.DIV(D), .LOCK_CNT(LK)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .clk_in  (clk_in),
    .clr_err (clr_err),
    .locked  (locked),
    .err     (err),
    .period  (period),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cap(input int v);
    return (v > 2*D) ? 2*D : v;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_good = 0; m_period = 0; m_errcnt = 0; m_stalled = 0;
    m_edge = 0; m_ref = 0; m_href = 0; m_lvl = '0;
  endtask

  // One clk edge of the model. A clk_in rise driven before edge n is
  // acted on at edge n+3 (two sync flops plus the registered edge pulse).
  task automatic model_edge(input logic lvl, input logic clr);
    int  since, hi;
    bit  rise, fall, tmo, bad, inc;
    m_edge++;
    m_lvl = {m_lvl[3:0], lvl};
    since = cap(m_edge - 1 - m_ref);
    hi    = cap(m_edge - 1 - m_href);
    rise  = m_lvl[3] && !m_lvl[4];
    fall  = !m_lvl[3] && m_lvl[4];
    tmo   = !rise && (since == 2*D);
    bad   = (rise && since != D) || tmo;
`ifdef CLK_RATIO_MONITOR_DUTY_EN
    if (fall && hi != D/2) bad = 1;
`else
    if (fall && hi < 0) bad = 1;
`endif
    inc = 0;
    case (m_state)
      M_IDLE: m_state = M_HUNT;
      M_HUNT: if (rise) begin m_state = M_LOCKING; m_good = 0; end
      M_LOCKING, M_LOCKED: begin
        if (bad) begin
          m_state = M_ERROR; inc = 1;
        end else if (rise && m_state == M_LOCKING) begin
          m_good++;
          if (m_good == LK) m_state = M_LOCKED;
        end
      end
      default: if (tmo && m_stalled == 0) inc = 1;
    endcase
    if (clr && m_edge > 1) m_state = M_HUNT;
    if (inc && m_errcnt < 255) m_errcnt++;
    if (rise) begin m_period = since; m_ref = m_edge - 1; m_href = m_edge - 1; m_stalled = 0; end
    else if (tmo) begin m_ref = m_edge - 1; m_stalled = 1; end
  endtask

  task automatic step(input logic lvl, input logic clr);
    @(negedge clk);
    clk_in  = lvl;
    clr_err = clr;
    @(posedge clk);
    model_edge(lvl, clr);
    #1;
    chk_val("locked",  32'(locked),  32'(m_state == M_LOCKED));
    chk_val("err",     32'(err),     32'(m_state == M_ERROR));
    chk_val("period",  32'(period),  32'(m_period));
    chk_val("err_cnt", 32'(err_cnt), 32'(m_errcnt));
  endtask

  task automatic run(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
    end
  endtask

  // Called right after a step; asserts reset between clk edges.
  task automatic do_reset();
    #2;
    reset_L = 1'b0;
    #1;
    chk_val("rst_locked",  32'(locked),  32'd0);
    chk_val("rst_err",     32'(err),     32'd0);
    chk_val("rst_period",  32'(period),  32'd0);
    chk_val("rst_err_cnt", 32'(err_cnt), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  int snap;

  initial begin
    model_reset();
    #1;
    chk_val("init_locked",  32'(locked),  32'd0);
    chk_val("init_err",     32'(err),     32'd0);
    chk_val("init_period",  32'(period),  32'd0);
    chk_val("init_err_cnt", 32'(err_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_L = 1'b1;

    // nominal clk/8, 50% duty
    run(4, 4, 8);
    chk_val("nom_locked", 32'(locked), 32'd1);
    chk_val("nom_period", 32'(period), 32'd8);
    chk_val("nom_err",    32'(err),    32'd0);
    chk_val("nom_errcnt", 32'(err_cnt), 32'd0);

    // one stretched period
    run(4, 6, 1);
    run(4, 4, 1);
    chk_val("str_period", 32'(period),  32'd10);
    chk_val("str_err",    32'(err),     32'd1);
    chk_val("str_locked", 32'(locked),  32'd0);
    chk_val("str_errcnt", 32'(err_cnt), 32'd1);
    step(1'b0, 1'b1);

    // clr_err on the same edge as a bad rise: restart wins, count still moves
    run(4, 4, 6);
    run(4, 6, 1);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk_val("coin_err",    32'(err),     32'd0);
    chk_val("coin_locked", 32'(locked),  32'd0);
    chk_val("coin_errcnt", 32'(err_cnt), 32'd2);
    run(0, 4, 1);

    // stopped clock while locked
    run(4, 4, 7);
    chk_val("pre_stall_locked", 32'(locked), 32'd1);
    snap = m_errcnt;
    run(4, 20, 1);
    chk_val("stall_err",    32'(err),     32'd1);
    chk_val("stall_errcnt", 32'(err_cnt), 32'(snap + 1));
    run(0, 40, 1);
    chk_val("stall2_errcnt", 32'(err_cnt), 32'(snap + 1));
    step(1'b0, 1'b1);
    run(4, 4, 7);
    chk_val("relock_locked", 32'(locked), 32'd1);

    // reset mid-period while locked
    run(4, 2, 1);
    do_reset();
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    run(4, 4, 7);
    chk_val("post_rst_locked", 32'(locked), 32'd1);
    chk_val("post_rst_err",    32'(err),    32'd0);

    // high 3 / low 5
    step(1'b0, 1'b1);
    run(3, 5, 8);
`ifdef CLK_RATIO_MONITOR_DUTY_EN
    chk_val("duty_err",    32'(err),     32'd1);
    chk_val("duty_errcnt", 32'(err_cnt), 32'd1);
`else
    chk_val("duty_locked", 32'(locked),  32'd1);
`endif

    // randomized waveforms, restarts and resets
    for (int s = 0; s < 80; s++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      run(4, 4, 1);
      else if (r < 75) run($urandom_range(1, 6), $urandom_range(1, 10), 1);
      else if (r < 85) step(1'b0, 1'b1);
      else if (r < 90) step(1'b1, 1'b1);
      else if (r < 96) run(0, $urandom_range(14, 40), 1);
      else             do_reset();
    end

    // error counter saturation
    step(1'b0, 1'b1);
    for (int it = 0; it < 300; it++) begin
      run(4, 6, 2);
      step(1'b0, 1'b1);
    end
    chk_val("sat_errcnt", 32'(err_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
